// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA definitions: instruction formats, opcode classes, field
// positions and the loader FSM states used by the encoder and the decoder.
package mips_isa_pkg;

    typedef enum logic [1:0] {
        FMT_R    = 2'b00,
        FMT_I    = 2'b01,
        FMT_J    = 2'b10,
        FMT_RSVD = 2'b11
    } fmt_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam int OPCODE_LSB = 26;
    localparam int RS_LSB     = 21;
    localparam int RT_LSB     = 16;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_LSB    = 0;
    localparam int TARGET_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCEPT = 2'b01,
        ST_WRITE  = 2'b10,
        ST_DONE   = 2'b11
    } state_e;

    // J and JAL form the 00001x class that the decoder treats as jumps.
    function automatic logic is_jump_op(input logic [5:0] op);
        return (op == OP_J) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: builds an R/I/J instruction word from its
// fields and reports whether the format/opcode pair is legal.
module instr_pack
    import mips_isa_pkg::*;
(
    input  logic [1:0]  fmt,
    input  logic [5:0]  opcode,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        legal
);

    always_comb begin
        word  = '0;
        legal = 1'b0;
        unique case (fmt_e'(fmt))
            FMT_R: begin
                // The opcode field is forced so a stray value cannot alias another class.
                word[OPCODE_LSB +: 6] = OP_RTYPE;
                word[RS_LSB +: 5]     = rs;
                word[RT_LSB +: 5]     = rt;
                word[RD_LSB +: 5]     = rd;
                word[SHAMT_LSB +: 5]  = shamt;
                word[FUNCT_LSB +: 6]  = funct;
                legal                 = 1'b1;
            end
            FMT_I: begin
                word[OPCODE_LSB +: 6] = opcode;
                word[RS_LSB +: 5]     = rs;
                word[RT_LSB +: 5]     = rt;
                word[IMM_LSB +: 16]   = imm;
                legal                 = (opcode != OP_RTYPE) && !is_jump_op(opcode);
            end
            FMT_J: begin
                word[OPCODE_LSB +: 6]  = opcode;
                word[TARGET_LSB +: 26] = target;
                legal                  = is_jump_op(opcode);
            end
            default: begin
                word  = '0;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Sequential instruction encoder/loader: accepts field bundles, packs legal
// ones and writes them to consecutive instruction-memory word addresses.
module instr_encoder
    import mips_isa_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_fmt,
    input  logic [5:0]            in_opcode,
    input  logic [4:0]            in_rs,
    input  logic [4:0]            in_rt,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_shamt,
    input  logic [5:0]            in_funct,
    input  logic [15:0]           in_imm,
    input  logic [25:0]           in_target,
    input  logic                  in_last,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   count
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [ADDR_WIDTH:0]   count_d;
    logic [31:0]           wdata_d;
    logic                  err_d, full_d;
    logic                  last_q, last_d;
    logic [31:0]           pack_word;
    logic                  pack_legal;

    instr_pack u_pack (
        .fmt    (in_fmt),
        .opcode (in_opcode),
        .rs     (in_rs),
        .rt     (in_rt),
        .rd     (in_rd),
        .shamt  (in_shamt),
        .funct  (in_funct),
        .imm    (in_imm),
        .target (in_target),
        .word   (pack_word),
        .legal  (pack_legal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mem_addr  <= BASE_ADDR;
            count     <= '0;
            mem_wdata <= '0;
            err       <= 1'b0;
            full      <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_addr  <= addr_d;
            count     <= count_d;
            mem_wdata <= wdata_d;
            err       <= err_d;
            full      <= full_d;
            last_q    <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = mem_addr;
        count_d = count;
        wdata_d = mem_wdata;
        err_d   = err;
        full_d  = full;
        last_d  = last_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    addr_d  = BASE_ADDR;
                    count_d = '0;
                    err_d   = 1'b0;
                    full_d  = 1'b0;
                    state_d = ST_ACCEPT;
                end
            end
            ST_ACCEPT: begin
                if (in_valid) begin
                    if (pack_legal) begin
                        wdata_d = pack_word;
                        last_d  = in_last;
                        state_d = ST_WRITE;
                    end else begin
                        // Illegal bundles are consumed so the loader never stalls on them.
                        err_d = 1'b1;
                        if (in_last) begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_WRITE: begin
                if (mem_ready) begin
                    count_d = count + 1'b1;
                    if (last_q) begin
                        addr_d  = mem_addr + 1'b1;
                        state_d = ST_DONE;
                    end else if (&mem_addr) begin
                        // Out of address space: stop rather than wrap over earlier words.
                        full_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        addr_d  = mem_addr + 1'b1;
                        state_d = ST_ACCEPT;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes decode straight from state so reset drops them without a clock.
    assign in_ready = (state_q == ST_ACCEPT);
    assign mem_we   = (state_q == ST_WRITE);
    assign busy     = (state_q == ST_ACCEPT) || (state_q == ST_WRITE);
    assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_instr_encoder.sv
// Directed scoreboard bench for instr_encoder: a default-width instance and a
// 2-bit-address instance to reach the full condition.
module tb_instr_encoder;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, start_b, in_valid_a, in_valid_b;
    logic [1:0]  in_fmt;
    logic [5:0]  in_opcode, in_funct;
    logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        in_last, mem_ready;

    logic        in_ready_a, mem_we_a, busy_a, done_a, err_a, full_a;
    logic [7:0]  mem_addr_a;
    logic [31:0] mem_wdata_a;
    logic [8:0]  count_a;
    logic        in_ready_b, mem_we_b, busy_b, done_b, err_b, full_b;
    logic [1:0]  mem_addr_b;
    logic [31:0] mem_wdata_b;
    logic [2:0]  count_b;

    wr_t sb_a[$];
    wr_t sb_b[$];
    int  n_checks = 0;
    int  n_fail = 0;
    bit  sel_b = 1'b0;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_WIDTH(8), .BASE_ADDR(8'd0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
        .in_last(in_last), .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
        .mem_ready(mem_ready), .busy(busy_a), .done(done_a), .err(err_a), .full(full_a),
        .count(count_a)
    );

    instr_encoder #(.ADDR_WIDTH(2), .BASE_ADDR(2'd0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
        .in_last(in_last), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_ready(mem_ready), .busy(busy_b), .done(done_b), .err(err_b), .full(full_b),
        .count(count_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at the falling edge: a write commits on the next rising edge.
    task automatic monitor();
        wr_t e;
        if (mem_we_a && mem_ready) begin
            if (sb_a.size() == 0) check("unexpected_write_a", 64'(sb_a.size()), 64'd1);
            else begin
                e = sb_a.pop_front();
                check("addr_a", 64'(mem_addr_a), 64'(e.addr));
                check("wdata_a", 64'(mem_wdata_a), 64'(e.data));
            end
        end
        if (mem_we_b && mem_ready) begin
            if (sb_b.size() == 0) check("unexpected_write_b", 64'(sb_b.size()), 64'd1);
            else begin
                e = sb_b.pop_front();
                check("addr_b", 64'({6'd0, mem_addr_b}), 64'(e.addr));
                check("wdata_b", 64'(mem_wdata_b), 64'(e.data));
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input bit b);
        if (b) start_b = 1'b1; else start_a = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic send(input int fmt, input int op, input int rs, input int rt, input int rd,
                        input int sh, input int fn, input int imm, input int tgt, input bit last,
                        input bit exp_accept, input bit exp_legal, input int exp_addr,
                        input logic [31:0] exp_word);
        bit accepted = 1'b0;
        int bound = exp_accept ? 20 : 6;
        wr_t e;
        in_fmt = fmt[1:0]; in_opcode = op[5:0]; in_rs = rs[4:0]; in_rt = rt[4:0];
        in_rd = rd[4:0]; in_shamt = sh[4:0]; in_funct = fn[5:0]; in_imm = imm[15:0];
        in_target = tgt[25:0]; in_last = last;
        if (exp_accept && exp_legal) begin
            e.addr = exp_addr[7:0];
            e.data = exp_word;
            if (sel_b) sb_b.push_back(e); else sb_a.push_back(e);
        end
        if (sel_b) in_valid_b = 1'b1; else in_valid_a = 1'b1;
        for (int i = 0; i < bound && !accepted; i++) begin
            @(negedge clk);
            monitor();
            if (sel_b ? in_ready_b : in_ready_a) accepted = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        in_last = 1'b0;
        check(exp_accept ? "accept_timeout" : "accepted_when_full", 64'(accepted), 64'(exp_accept));
    endtask

    task automatic wait_done(input int bound);
        bit got = 1'b0;
        for (int i = 0; i < bound && !got; i++) begin
            @(negedge clk);
            monitor();
            if (sel_b ? done_b : done_a) got = 1'b1;
            @(posedge clk);
            #1;
        end
        check("done_timeout", 64'(got), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; in_valid_a = 1'b0; in_valid_b = 1'b0;
        in_fmt = '0; in_opcode = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0;
        in_funct = '0; in_imm = '0; in_target = '0; in_last = 1'b0; mem_ready = 1'b1;

        // Reset values
        #12;
        check("rst_in_ready", 64'(in_ready_a), 64'd0);
        check("rst_mem_we", 64'(mem_we_a), 64'd0);
        check("rst_mem_addr", 64'(mem_addr_a), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata_a), 64'd0);
        check("rst_flags", 64'({busy_a, done_a, err_a, full_a}), 64'd0);
        check("rst_count", 64'(count_a), 64'd0);
        check("rst_b_state", 64'({busy_b, done_b, count_b}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        check("idle_in_ready", 64'(in_ready_a), 64'd0);

        // Single R-type
        pulse_start(1'b0);
        check("accept_in_ready", 64'(in_ready_a), 64'd1);
        check("accept_busy", 64'(busy_a), 64'd1);
        send(0, 6'h3f, 1, 2, 3, 0, 6'h20, 0, 0, 1'b1, 1'b1, 1'b1, 0, 32'h00221820);
        wait_done(10);
        check("t1_count", 64'(count_a), 64'd1);
        check("t1_err", 64'(err_a), 64'd0);
        check("t1_full", 64'(full_a), 64'd0);
        check("t1_busy", 64'(busy_a), 64'd0);

        // I-type then J-type
        pulse_start(1'b0);
        check("t2_count_clear", 64'(count_a), 64'd0);
        check("t2_done_clear", 64'(done_a), 64'd0);
        send(1, 6'b100011, 29, 8, 0, 0, 0, 16'h0004, 0, 1'b0, 1'b1, 1'b1, 0, 32'h8FA80004);
        send(2, 6'b000010, 0, 0, 0, 0, 0, 0, 26'h0000100, 1'b1, 1'b1, 1'b1, 1, 32'h08000100);
        wait_done(10);
        check("t2_count", 64'(count_a), 64'd2);
        check("t2_addr", 64'(mem_addr_a), 64'd2);

        // Illegal I-type and J-type dropped, then a legal R-type
        pulse_start(1'b0);
        send(1, 6'b000010, 1, 2, 0, 0, 0, 16'h1234, 0, 1'b0, 1'b1, 1'b0, 0, 32'h0);
        check("t3_err", 64'(err_a), 64'd1);
        check("t3_count0", 64'(count_a), 64'd0);
        check("t3_still_accept", 64'(in_ready_a), 64'd1);
        send(2, 6'b000100, 0, 0, 0, 0, 0, 0, 26'h3, 1'b0, 1'b1, 1'b0, 0, 32'h0);
        send(0, 0, 4, 5, 6, 2, 6'h00, 0, 0, 1'b1, 1'b1, 1'b1, 0, 32'h00853080);
        wait_done(10);
        check("t3_count", 64'(count_a), 64'd1);
        check("t3_err_sticky", 64'(err_a), 64'd1);

        // Reserved format with last ends the session without a write
        pulse_start(1'b0);
        check("t4_err_clear", 64'(err_a), 64'd0);
        send(3, 6'h08, 1, 1, 1, 1, 1, 1, 1, 1'b1, 1'b1, 1'b0, 0, 32'h0);
        wait_done(3);
        check("t4_err", 64'(err_a), 64'd1);
        check("t4_count", 64'(count_a), 64'd0);

        // Memory back-pressure
        pulse_start(1'b0);
        mem_ready = 1'b0;
        send(1, 6'b001000, 1, 2, 0, 0, 0, 16'hFFFF, 0, 1'b1, 1'b1, 1'b1, 0, 32'h2022FFFF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            monitor();
            check("stall_we", 64'(mem_we_a), 64'd1);
            check("stall_addr", 64'(mem_addr_a), 64'd0);
            check("stall_wdata", 64'(mem_wdata_a), 64'h2022FFFF);
            check("stall_in_ready", 64'(in_ready_a), 64'd0);
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        wait_done(5);
        check("stall_count", 64'(count_a), 64'd1);

        // Address space exhaustion on the 2-bit instance
        sel_b = 1'b1;
        pulse_start(1'b1);
        for (int i = 0; i < 4; i++)
            send(0, 0, 0, 0, i + 1, 0, 6'h20, 0, 0, 1'b0, 1'b1, 1'b1, i,
                 (32'(i + 1) << 11) | 32'h20);
        send(0, 0, 0, 0, 9, 0, 6'h20, 0, 0, 1'b1, 1'b0, 1'b1, 0, 32'h0);
        check("full_flag", 64'(full_b), 64'd1);
        check("full_done", 64'(done_b), 64'd1);
        check("full_count", 64'(count_b), 64'd4);
        check("full_addr", 64'(mem_addr_b), 64'd3);
        check("full_err", 64'(err_b), 64'd0);
        sel_b = 1'b0;

        // Asynchronous reset during a stalled write
        pulse_start(1'b0);
        mem_ready = 1'b0;
        send(0, 0, 7, 7, 7, 0, 6'h25, 0, 0, 1'b1, 1'b1, 1'b1, 0, 32'h00E73825);
        check("pre_rst_we", 64'(mem_we_a), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_we", 64'(mem_we_a), 64'd0);
        check("async_rst_busy", 64'(busy_a), 64'd0);
        sb_a.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_ready = 1'b1;
        tick();
        check("post_rst_count", 64'(count_a), 64'd0);
        check("post_rst_done", 64'(done_a), 64'd0);
        check("post_rst_idle", 64'({in_ready_a, busy_a, mem_we_a}), 64'd0);

        check("sb_a_empty", 64'(sb_a.size()), 64'd0);
        check("sb_b_empty", 64'(sb_b.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
